// File: rtl/spike_link_tx.sv
// spike_link_tx: transmit end of the FPGA-to-FPGA spike link.
// Queues single-cycle spike events as a count and drives each one onto a pin
// as a pulse of fixed high width followed by a guaranteed low gap, so the
// remote rack can sample every event reliably. One instance per output pin.
//
// Optional feature: define SPIKE_TX_DROP_CNT_EN to count events lost to queue
// saturation (saturating 16-bit counter). Without it dropped_count is 16'd0.
module spike_link_tx #(
    parameter int PEND_W   = 4,
    parameter int HIGH_CYC = 2,
    parameter int LOW_CYC  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              spike_in,
    output logic              spike_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic [31:0]       sent_count,
    output logic [15:0]       dropped_count
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // Phase counter must hold the larger of the two reload values
    localparam int CNT_MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int CNT_W       = (CNT_MAX_CYC > 1) ? $clog2(CNT_MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              spike_out_r;
    logic              busy_r;
    logic [PEND_W-1:0] pending_r;
    logic [PEND_W-1:0] pending_nxt_s;
    logic [31:0]       sent_count_r;
    logic              start_s;
    logic              accept_s;
    logic              pend_nz_s;
    logic              pend_full_s;
    logic              cnt_zero_s;
    logic              can_start_s;

    assign pend_nz_s   = (pending_r != PEND_ZERO);
    assign pend_full_s = (pending_r == PEND_MAX);
    assign cnt_zero_s  = (cnt_r == CNT_ZERO);
    assign can_start_s = enable && pend_nz_s;

    // A new event is always taken when a pulse starts in the same cycle,
    // because the start frees a slot even if the queue was full.
    assign accept_s = spike_in && (!pend_full_s || start_s);

    // Next-state logic: IDLE -> HIGH -> LOW -> (HIGH back-to-back | IDLE)
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (can_start_s) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = HIGH_LOAD;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_HIGH: begin
                if (!cnt_zero_s) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = LOW_LOAD;
                end
            end
            ST_LOW: begin
                if (!cnt_zero_s) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else if (can_start_s) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = HIGH_LOAD;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Pending-queue count: +1 on accepted event, -1 on pulse start
    always_comb begin
        pending_nxt_s = pending_r;
        if (accept_s && !start_s) begin
            pending_nxt_s = pending_r + PEND_ONE;
        end else if (start_s && !accept_s) begin
            pending_nxt_s = pending_r - PEND_ONE;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // FSM state, phase counter and registered pin/status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            spike_out_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            spike_out_r <= (state_nxt_s == ST_HIGH);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Pending count and sent-pulse counter (sent_count wraps naturally)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_r    <= PEND_ZERO;
            sent_count_r <= 32'd0;
        end else begin
            pending_r <= pending_nxt_s;
            if (start_s) begin
                sent_count_r <= sent_count_r + 32'd1;
            end else begin
                sent_count_r <= sent_count_r;
            end
        end
    end

`ifdef SPIKE_TX_DROP_CNT_EN
    logic        drop_s;
    logic [15:0] dropped_count_r;

    // Saturating increment so a long overload never wraps back to a small value
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    assign drop_s = spike_in && !accept_s;

    // Count events lost because the queue was full and nothing left it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dropped_count_r <= 16'd0;
        end else if (drop_s) begin
            dropped_count_r <= sat_inc16(dropped_count_r);
        end else begin
            dropped_count_r <= dropped_count_r;
        end
    end

    assign dropped_count = dropped_count_r;
`else
    assign dropped_count = 16'd0;
`endif

    assign spike_out  = spike_out_r;
    assign busy       = busy_r;
    assign pending    = pending_r;
    assign sent_count = sent_count_r;

endmodule

// File: tb/tb_spike_link_tx.sv
// Bench for spike_link_tx: directed scenarios plus random traffic, checked
// against a timing-level reference model and a scoreboard of pulse starts.
module tb_spike_link_tx;

    localparam int PEND_W = 4;
    localparam int HC     = 2;
    localparam int LC     = 2;
    localparam int MAXP   = (1 << PEND_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              spike_in;
    logic              spike_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic [31:0]       sent_count;
    logic [15:0]       dropped_count;

    spike_link_tx #(.PEND_W(PEND_W), .HIGH_CYC(HC), .LOW_CYC(LC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .spike_in     (spike_in),
        .spike_out    (spike_out),
        .busy         (busy),
        .pending      (pending),
        .sent_count   (sent_count),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pulse may start at an edge only when enable is high,
    // events are queued and at least HC+LC edges have passed since the
    // previous start. Output/busy follow from time since the last start.
    int          ecount      = 0;
    bit          model_valid = 0;
    int          m_pend      = 0;
    logic [31:0] m_sent      = 32'd0;
    int          m_drop      = 0;
    int          last_start  = 0;
    bit          has_start   = 0;
    bit          m_free;
    bit          m_start;
    bit          m_acc;
    int          exp_q[$];

    always @(posedge clk) begin
        ecount++;
        if (reset_n === 1'b0) begin
            m_pend      = 0;
            m_sent      = 32'd0;
            m_drop      = 0;
            has_start   = 0;
            model_valid = 1;
            exp_q.delete();
        end else if (model_valid) begin
            m_free  = !has_start || (ecount >= last_start + HC + LC);
            m_start = enable && (m_pend != 0) && m_free;
            m_acc   = spike_in && ((m_pend < MAXP) || m_start);
`ifdef SPIKE_TX_DROP_CNT_EN
            if (spike_in && !m_acc && m_drop < 65535) m_drop = m_drop + 1;
`endif
            m_pend = m_pend + (m_acc ? 1 : 0) - (m_start ? 1 : 0);
            if (m_start) begin
                m_sent     = m_sent + 32'd1;
                last_start = ecount;
                has_start  = 1;
                exp_q.push_back(ecount);
            end
        end
    end

    function automatic bit m_out();
        return has_start && (ecount - last_start < HC);
    endfunction

    function automatic bit m_busy();
        return has_start && (ecount - last_start < HC + LC);
    endfunction

    // Monitor: per-cycle state comparison plus scoreboard of pulse start times
    logic prev_out = 1'b0;
    int   exp_edge;
    always @(negedge clk) begin
        if (model_valid) begin
            check("spike_out", 64'(spike_out), 64'(m_out()));
            check("busy", 64'(busy), 64'(m_busy()));
            check("pending", 64'(pending), 64'(m_pend));
            check("sent_count", 64'(sent_count), 64'(m_sent));
            check("dropped_count", 64'(dropped_count), 64'(m_drop));
            if (spike_out === 1'b1 && prev_out === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'(1), 64'(0));
                end else begin
                    exp_edge = exp_q.pop_front();
                    check("pulse_start_edge", 64'(ecount), 64'(exp_edge));
                end
            end
            prev_out = spike_out;
        end
    end

    task automatic step(input logic r, input logic e, input logic s);
        @(negedge clk);
        reset_n  = r;
        enable   = e;
        spike_in = s;
    endtask

    // Returns at a negedge where spike_out is high, or flags a timeout
    task automatic wait_high(input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (spike_out === 1'b1) seen = 1;
            else @(negedge clk);
        end
        if (!seen) check("wait_high_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b1;
        spike_in = 1'b1;

        // Reset held three cycles with spike_in high
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("rst_spike_out", 64'(spike_out), 64'(0));
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_sent", 64'(sent_count), 64'(0));

        // Single event
        step(1'b1, 1'b1, 1'b1);
        repeat (8) step(1'b1, 1'b1, 1'b0);
        check("single_sent", 64'(sent_count), 64'(1));
        check("single_pending", 64'(pending), 64'(0));

        // Five consecutive events -> back-to-back pulses
        repeat (5) step(1'b1, 1'b1, 1'b1);
        repeat (24) step(1'b1, 1'b1, 1'b0);
        check("burst_sent", 64'(sent_count), 64'(6));

        // Saturate the queue while disabled, then drain
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0);
        end
        check("sat_pending", 64'(pending), 64'(15));
        check("sat_spike_out", 64'(spike_out), 64'(0));
`ifdef SPIKE_TX_DROP_CNT_EN
        check("sat_dropped", 64'(dropped_count), 64'(5));
`endif
        repeat (70) step(1'b1, 1'b1, 1'b0);
        check("drain_pending", 64'(pending), 64'(0));
        check("drain_sent", 64'(sent_count), 64'(21));

        // Disable during a HIGH phase: pulse completes, then idle
        repeat (3) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        wait_high(10);
        enable = 1'b0;
        repeat (10) step(1'b1, 1'b0, 1'b0);
        check("dis_pending", 64'(pending), 64'(2));
        check("dis_busy", 64'(busy), 64'(0));
        repeat (12) step(1'b1, 1'b1, 1'b0);
        check("dis_resume_pending", 64'(pending), 64'(0));

        // Reset while a pulse is high with events queued
        repeat (6) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        wait_high(10);
        check("pre_rst_pending", 64'(pending), 64'(5));
        reset_n = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        check("midrst_spike_out", 64'(spike_out), 64'(0));
        check("midrst_pending", 64'(pending), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_sent", 64'(sent_count), 64'(0));
        check("midrst_dropped", 64'(dropped_count), 64'(0));

        // Random traffic with occasional disable and reset
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 199) != 0),
                 1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 2) == 0));
        end
        repeat (80) step(1'b1, 1'b1, 1'b0);
        check("final_pending", 64'(pending), 64'(0));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
